// File: rtl/slice_arbiter_rr_if.sv
// Request/grant bundle between the requesters and the round-robin slice arbiter.
// With SLICE_ARB_STATS_EN defined the bundle also carries the grant counter.
interface slice_arbiter_rr_if #(
    parameter int N_REQ = 4,
    parameter int N     = 3
);
    logic [N-1:0]     i_k;
    logic [N_REQ-1:0] i_req;
    logic [N_REQ-1:0] o_grant;
    logic             o_slice_end;
    logic             o_busy;
`ifdef SLICE_ARB_STATS_EN
    logic [15:0]      o_grant_cnt;
`endif

`ifdef SLICE_ARB_STATS_EN
    modport master (output i_k, i_req, input o_grant, o_slice_end, o_busy, o_grant_cnt);
    modport slave  (input i_k, i_req, output o_grant, o_slice_end, o_busy, o_grant_cnt);
`else
    modport master (output i_k, i_req, input o_grant, o_slice_end, o_busy);
    modport slave  (input i_k, i_req, output o_grant, o_slice_end, o_busy);
`endif
endinterface

// File: rtl/slice_arbiter_rr.sv
// Round-robin time-slice arbiter: each grant lasts k cycles, handover has no idle bubble.
// Optional grant statistics counter is enabled by defining SLICE_ARB_STATS_EN.
module slice_arbiter_rr #(
    parameter int N_REQ = 4,
    parameter int N     = 3
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    slice_arbiter_rr_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_reg;
    logic [N_REQ-1:0] grant_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [N-1:0]     count_reg;
    logic [N-1:0]     k_lat_reg;

    logic [IDX_W-1:0] arb_base;
    logic [IDX_W-1:0] win_off;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] rot_req;
    logic [N_REQ-1:0] win_onehot;
    logic             any_req;
    logic             slice_end;
    logic             released;
    logic             slice_over;
    logic             grant_issue;
    logic [N-1:0]     k_eff;

    function automatic logic [IDX_W-1:0] mod_idx(input int v);
        return IDX_W'(v % N_REQ);
    endfunction

    // While granting, the search base is the pointer value the slice end will install.
    assign arb_base = (state_reg == GRANT) ? mod_idx(int'(idx_reg) + 1) : ptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_req[gi]    = bus.i_req[mod_idx(int'(arb_base) + gi)];
            assign win_onehot[gi] = (win_idx == IDX_W'(gi));
        end
    endgenerate

    // Lowest set bit of the rotated vector is the first requester at or after the base.
    always_comb begin
        win_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) win_off = IDX_W'(i);
        end
    end

    assign win_idx     = mod_idx(int'(arb_base) + int'(win_off));
    assign any_req     = |bus.i_req;
    assign k_eff       = (bus.i_k == '0) ? N'(1) : bus.i_k;
    assign slice_end   = (state_reg == GRANT) && (count_reg == k_lat_reg - N'(1));
    assign released    = (state_reg == GRANT) && !bus.i_req[idx_reg];
    assign slice_over  = slice_end || released;
    assign grant_issue = any_req && ((state_reg == IDLE) || slice_over);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
            ptr_reg   <= '0;
            count_reg <= '0;
            k_lat_reg <= N'(1);
        end else begin
            if ((state_reg == GRANT) && !slice_over) begin
                count_reg <= count_reg + N'(1);
            end else if (grant_issue) begin
                state_reg <= GRANT;
                grant_reg <= win_onehot;
                idx_reg   <= win_idx;
                count_reg <= '0;
                k_lat_reg <= k_eff;
            end else if (state_reg == GRANT) begin
                state_reg <= IDLE;
                grant_reg <= '0;
                count_reg <= '0;
            end
            if (slice_over) ptr_reg <= arb_base;
        end
    end

`ifdef SLICE_ARB_STATS_EN
    logic [15:0] grant_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            grant_cnt_reg <= '0;
        end else if (grant_issue && (grant_cnt_reg != 16'hFFFF)) begin
            grant_cnt_reg <= grant_cnt_reg + 16'd1;
        end
    end

    assign bus.o_grant_cnt = grant_cnt_reg;
`endif

    assign bus.o_grant     = grant_reg;
    assign bus.o_slice_end = slice_end;
    assign bus.o_busy      = |grant_reg;
endmodule

// File: tb/tb_slice_arbiter_rr.sv
// Directed bench for slice_arbiter_rr: each step queues the expected post-edge outputs
// and checks them one edge later.
module tb_slice_arbiter_rr;
    localparam int N_REQ = 4;
    localparam int N     = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slice_arbiter_rr_if #(.N_REQ(N_REQ), .N(N)) bus ();

    slice_arbiter_rr #(.N_REQ(N_REQ), .N(N)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    typedef struct {
        logic [N_REQ-1:0] grant;
        logic             se;
        logic             busy;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   step_no      = 0;

    task automatic cyc(input logic rst, input logic [N_REQ-1:0] req, input logic [N-1:0] k,
                       input logic [N_REQ-1:0] eg, input logic ese);
        exp_t e;
        exp_t got;
        rst_n     = rst;
        bus.i_req = req;
        bus.i_k   = k;
        e.grant = eg;
        e.se    = ese;
        e.busy  = |eg;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        step_no++;
        tests_run++;
        assert (bus.o_grant === got.grant) else begin
            tests_failed++;
            $error("FAIL grant step %0d: observed %b expected %b", step_no, bus.o_grant, got.grant);
        end
        tests_run++;
        assert (bus.o_slice_end === got.se) else begin
            tests_failed++;
            $error("FAIL slice_end step %0d: observed %b expected %b", step_no, bus.o_slice_end, got.se);
        end
        tests_run++;
        assert (bus.o_busy === got.busy) else begin
            tests_failed++;
            $error("FAIL busy step %0d: observed %b expected %b", step_no, bus.o_busy, got.busy);
        end
        $display("[TB] step %0d rst_n=%b req=%b k=%0d -> grant=%b slice_end=%b busy=%b",
                 step_no, rst, req, k, bus.o_grant, bus.o_slice_end, bus.o_busy);
    endtask

    initial begin
        // Reset held two edges with everyone requesting
        cyc(1'b0, 4'b1111, 3'd2, 4'b0000, 1'b0);
        cyc(1'b0, 4'b1111, 3'd2, 4'b0000, 1'b0);
`ifdef SLICE_ARB_STATS_EN
        tests_run++;
        assert (bus.o_grant_cnt === 16'd0) else begin
            tests_failed++;
            $error("FAIL grant_cnt_reset: observed %0d expected 0", bus.o_grant_cnt);
        end
`endif
        // Full contention, k=2: 0001,0010,0100,1000,0001
        cyc(1'b1, 4'b1111, 3'd2, 4'b0001, 1'b0);
        cyc(1'b1, 4'b1111, 3'd2, 4'b0001, 1'b1);
        cyc(1'b1, 4'b1111, 3'd2, 4'b0010, 1'b0);
        cyc(1'b1, 4'b1111, 3'd2, 4'b0010, 1'b1);
        cyc(1'b1, 4'b1111, 3'd2, 4'b0100, 1'b0);
        cyc(1'b1, 4'b1111, 3'd2, 4'b0100, 1'b1);
        cyc(1'b1, 4'b1111, 3'd2, 4'b1000, 1'b0);
        cyc(1'b1, 4'b1111, 3'd2, 4'b1000, 1'b1);
        cyc(1'b1, 4'b1111, 3'd2, 4'b0001, 1'b0);
        cyc(1'b1, 4'b1111, 3'd2, 4'b0001, 1'b1);
        // Expiry with no requests -> idle, pointer now 1
        cyc(1'b1, 4'b0000, 3'd2, 4'b0000, 1'b0);
        // Single requester 1, k=3: continuous grant, slice_end every 3rd cycle
        for (int r = 0; r < 3; r++) begin
            cyc(1'b1, 4'b0010, 3'd3, 4'b0010, 1'b0);
            cyc(1'b1, 4'b0010, 3'd3, 4'b0010, 1'b0);
            cyc(1'b1, 4'b0010, 3'd3, 4'b0010, 1'b1);
        end
        // Simultaneous expiry and release -> idle, pointer now 2
        cyc(1'b1, 4'b0000, 3'd3, 4'b0000, 1'b0);
        // One-cycle slice for requester 3 moves the pointer to 0
        cyc(1'b1, 4'b1000, 3'd1, 4'b1000, 1'b1);
        // Early release: requester 0 drops in its 2nd granted cycle
        cyc(1'b1, 4'b0101, 3'd5, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0101, 3'd5, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0100, 3'd5, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0100, 3'd5, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0100, 3'd5, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0100, 3'd5, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0100, 3'd5, 4'b0100, 1'b1);
        // Re-grant with k=2, then k changes to 6 mid-slice
        cyc(1'b1, 4'b0100, 3'd2, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0100, 3'd6, 4'b0100, 1'b1);
        for (int c = 0; c < 5; c++) cyc(1'b1, 4'b0100, 3'd6, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0100, 3'd6, 4'b0100, 1'b1);
        // k=0 behaves as 1: slice_end every cycle
        for (int c = 0; c < 3; c++) cyc(1'b1, 4'b0100, 3'd0, 4'b0100, 1'b1);
        cyc(1'b1, 4'b0110, 3'd0, 4'b0010, 1'b1);
        cyc(1'b1, 4'b0110, 3'd0, 4'b0100, 1'b1);
        cyc(1'b1, 4'b0110, 3'd0, 4'b0010, 1'b1);
        cyc(1'b1, 4'b0000, 3'd0, 4'b0000, 1'b0);
        // Reset mid-slice (count=1, k=4)
        cyc(1'b1, 4'b0110, 3'd4, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0110, 3'd4, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0110, 3'd4, 4'b0000, 1'b0);
`ifdef SLICE_ARB_STATS_EN
        tests_run++;
        assert (bus.o_grant_cnt === 16'd0) else begin
            tests_failed++;
            $error("FAIL grant_cnt_midreset: observed %0d expected 0", bus.o_grant_cnt);
        end
`endif
        // Restart from pointer 0 with one-cycle slices: five grants
        cyc(1'b1, 4'b1111, 3'd1, 4'b0001, 1'b1);
        cyc(1'b1, 4'b1111, 3'd1, 4'b0010, 1'b1);
        cyc(1'b1, 4'b1111, 3'd1, 4'b0100, 1'b1);
        cyc(1'b1, 4'b1111, 3'd1, 4'b1000, 1'b1);
        cyc(1'b1, 4'b1111, 3'd1, 4'b0001, 1'b1);
`ifdef SLICE_ARB_STATS_EN
        tests_run++;
        assert (bus.o_grant_cnt === 16'd5) else begin
            tests_failed++;
            $error("FAIL grant_cnt_five: observed %0d expected 5", bus.o_grant_cnt);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/slice_arbiter_rr.md
Name: slice_arbiter_rr

Overview:
- Round-robin time-slice arbiter that shares one resource among N_REQ requesters.
- Each grant lasts a programmable slice of k cycles, timed by an internal modulo-k slice counter; the counter's rollover ends the slice.
- Sits in front of the shared counter/datapath and sequences which requester owns it, hands over without idle bubbles, and reports slice ends.

Parameters:
N_REQ, 4, number of requesters (2..8)
N, 3, width of slice-length input i_k

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset_n  in  1  synchronous active-low reset
i_k  in  N  slice length in cycles; sampled only at grant start; 0 treated as 1
i_req  in  N_REQ  request vector, level-sensitive, bit i = requester i
o_grant  out  N_REQ  registered one-hot grant, all-zero when idle
o_slice_end  out  1  high during the last cycle of a full-length slice
o_busy  out  1  high when any grant is active (equals |o_grant)

Behaviour:
- Reset (i_reset_n=0 sampled at edge): state IDLE, o_grant=0, slice count=0, latched k=1, RR pointer p=0. o_slice_end=0 and o_busy=0 during and after reset until a grant is issued. Reset mid-slice aborts the slice immediately, with no o_slice_end.
- States: IDLE, GRANT.
- Arbitration function: search i_req starting at index p upward, modulo N_REQ. The first set bit wins.
- IDLE: if i_req!=0 at edge, go to GRANT. o_grant=one-hot(winner) from the next cycle (1-cycle latency), count=0, k_lat=max(i_k,1). Otherwise stay in IDLE.
- GRANT: count increments by 1 each cycle. o_slice_end = (state==GRANT) && (count==k_lat-1), combinational from registers. A slice is exactly k_lat cycles long.
- Slice expiry (count==k_lat-1 at edge):
  - p = granted index+1 mod N_REQ; count wraps to 0.
  - Re-arbitrate with the new p. If any request is present, the new one-hot grant appears in the next cycle with no idle bubble, and k_lat is re-sampled.
  - If no request is present, go to IDLE.
  - The same requester may win again if it is the only one requesting.
- Early release: granted requester's i_req bit is 0 at an edge before expiry:
  - Slice terminates and o_slice_end is not asserted.
  - p = granted+1; re-arbitrate exactly as on expiry.
- Simultaneous expiry and release: treated as expiry, so o_slice_end was high that cycle.
- i_k changes mid-slice have no effect until the next grant.
- Requests from non-granted requesters never pre-empt an active slice.
- k_lat=1: o_slice_end is high in every granted cycle; a single requester holding its request sees a continuous grant and o_slice_end=1 each cycle.
- Count width N; maximum slice 2^N-1 cycles.

Optional Feature:
- Macro SLICE_ARB_STATS_EN.
- Defined: adds output o_grant_cnt [15:0]. It increments by 1 at each new grant issue, including back-to-back re-grants to the same requester. It saturates at 16'hFFFF and is cleared by reset.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold i_reset_n=0 for 2 edges with i_req=4'b1111 -> o_grant=0, o_busy=0, o_slice_end=0. First grant after release is 4'b0001.
- Single requester, i_k=3, i_req=4'b0010 held from edge t -> o_grant=0010 at t+1..t+3 and continuing. o_slice_end=1 at t+3, t+6, t+9.
- Full contention, i_k=2, i_req=4'b1111 held -> grant order 0001, 0010, 0100, 1000, 0001, each for 2 cycles, no gaps. o_slice_end high in the 2nd cycle of each slice.
- Early release: i_k=5, req 0001 and 0100; drop bit 0 in the 2nd granted cycle -> grant moves to 0100 at the next edge, no o_slice_end for requester 0. Requester 2 gets a full 5-cycle slice.
- i_k=0 and mid-slice i_k change: i_k=0 -> 1-cycle slices with o_slice_end every cycle. Change i_k 2->6 mid-slice -> current slice stays 2 cycles, next slice is 6.
- Reset mid-slice (count=1, i_k=4) -> the cycle after the reset edge has o_grant=0, and p=0 on restart. With SLICE_ARB_STATS_EN, o_grant_cnt=0 after reset and equals 5 after five grants.
